// File: rtl/sequencer_ms_pkg.sv
// sequencer_ms shared types.
// State and error-cause encodings plus a width helper.
package sequencer_ms_pkg;

   typedef enum logic [2:0] {
      SRST,
      SREAD,
      SLOAD,
      SCALC,
      SWRITE,
      SPAUSE,
      SFINISH,
      SERR
   } seq_state_t;

   typedef enum logic [1:0] {
      EC_NONE,
      EC_EXT,
      EC_TIMEOUT,
      EC_ABORT
   } err_cause_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sequencer_ms_if.sv
// sequencer_ms control/status bundle.
// master drives control, slave (the sequencer) drives status.
interface sequencer_ms_if
   import sequencer_ms_pkg::*;
#(
   parameter int NUM_LOADS = 2,
   parameter int CNT_W     = 16
);
   localparam int LIDX_W = clog2_min1(NUM_LOADS);

   logic              start;
   logic              nxt_line;
   logic              finish;
   logic              err;
   logic              abort;
   logic              step_mode;
   logic              step;
   seq_state_t        q;
   logic [LIDX_W-1:0] load_idx;
   logic [CNT_W-1:0]  instr_count;
   err_cause_t        err_cause;
   logic              busy;

   modport slave (
      input  start, nxt_line, finish, err,
      input  abort, step_mode, step,
      output q, load_idx, instr_count,
      output err_cause, busy
   );

   modport master (
      output start, nxt_line, finish, err,
      output abort, step_mode, step,
      input  q, load_idx, instr_count,
      input  err_cause, busy
   );

endinterface

// File: rtl/sequencer_ms_watchdog.sv
// SCALC watchdog counter.
// expired flags the last allowed calc cycle; 0 limit disables it.
module sequencer_ms_watchdog
   import sequencer_ms_pkg::*;
#(
   parameter int MAX_CALC_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW  = clog2_min1(MAX_CALC_CYCLES + 1);
   localparam int LIM = (MAX_CALC_CYCLES > 0) ?
                        MAX_CALC_CYCLES - 1 : 0;

   logic [CW-1:0] cnt;

   // count calc cycles; parked at the limit so it never wraps
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 1'b1;
   end

   assign expired = (MAX_CALC_CYCLES > 0) &&
                    (cnt == CW'(LIM));

endmodule

// File: rtl/sequencer_ms.sv
// Multi-stage CPU control sequencer.
// FSM, load index, retired counter and sticky error cause.
module sequencer_ms
   import sequencer_ms_pkg::*;
#(
   parameter int NUM_LOADS       = 2,
   parameter int MAX_CALC_CYCLES = 64,
   parameter int CNT_W           = 16
) (
   input logic           clk,
   input logic           rst,
   sequencer_ms_if.slave bus
);
   localparam int LIDX_W = clog2_min1(NUM_LOADS);
   localparam logic [LIDX_W-1:0] LAST =
      LIDX_W'(NUM_LOADS - 1);

   seq_state_t        q, q_n;
   logic [LIDX_W-1:0] lidx, lidx_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   err_cause_t        cause, cause_n;
   logic              in_calc;
   logic              expired;

   assign in_calc = (q == SCALC);

   sequencer_ms_watchdog #(
      .MAX_CALC_CYCLES(MAX_CALC_CYCLES)
   ) u_wd (
      .clk    (clk),
      .rst    (rst),
      .clr    (!in_calc),
      .en     (in_calc),
      .expired(expired)
   );

   // state and bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= SRST;
         lidx  <= '0;
         cnt   <= '0;
         cause <= EC_NONE;
      end else begin
         q     <= q_n;
         lidx  <= lidx_n;
         cnt   <= cnt_n;
         cause <= cause_n;
      end
   end

   // next state: err > abort > watchdog > normal flow
   always_comb begin
      q_n     = q;
      lidx_n  = lidx;
      cnt_n   = cnt;
      cause_n = cause;
      if (q != SERR && (bus.err || bus.abort)) begin
         q_n     = SERR;
         cause_n = bus.err ? EC_EXT : EC_ABORT;
      end else begin
         unique case (q)
            SRST: begin
               if (bus.start) q_n = SREAD;
            end
            SREAD: begin
               q_n    = SLOAD;
               lidx_n = '0;
            end
            SLOAD: begin
               if (lidx != LAST) begin
                  lidx_n = lidx + 1'b1;
               end else begin
                  q_n    = SCALC;
                  lidx_n = '0;
               end
            end
            SCALC: begin
               if (bus.finish) begin
                  q_n = SFINISH;
               end else if (bus.nxt_line) begin
                  q_n = SWRITE;
               end else if (expired) begin
                  q_n     = SERR;
                  cause_n = EC_TIMEOUT;
               end
            end
            SWRITE: begin
               if (cnt != '1) cnt_n = cnt + 1'b1;
               q_n = bus.step_mode ? SPAUSE : SREAD;
            end
            SPAUSE: begin
               if (bus.step || !bus.step_mode)
                  q_n = SREAD;
            end
            SFINISH: begin
               if (bus.start) begin
                  q_n   = SREAD;
                  cnt_n = '0;
               end
            end
            SERR: begin
               q_n = SERR;
            end
         endcase
      end
   end

   assign bus.q           = q;
   assign bus.load_idx    = lidx;
   assign bus.instr_count = cnt;
   assign bus.err_cause   = cause;
   assign bus.busy        = (q == SREAD)  ||
                            (q == SLOAD)  ||
                            (q == SCALC)  ||
                            (q == SWRITE) ||
                            (q == SPAUSE);

endmodule

// File: tb/tb_sequencer_ms.sv
// Bench for sequencer_ms: directed scenarios then random traffic.
// Every cycle is compared against a cycle-count reference model.
module tb_sequencer_ms;
   import sequencer_ms_pkg::*;

   localparam int NL   = 3;
   localparam int MAXC = 4;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   seq_state_t ms    = SRST;
   int         ml    = 0;
   int         mcalc = 0;
   int         mn    = 0;
   err_cause_t me    = EC_NONE;

   sequencer_ms_if #(.NUM_LOADS(NL), .CNT_W(CW)) bus ();

   sequencer_ms #(
      .NUM_LOADS      (NL),
      .MAX_CALC_CYCLES(MAXC),
      .CNT_W          (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] o,
                      input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, o, e);
      end
   endtask

   // behavioural reference: phase plus elapsed-cycle counts
   task automatic model();
      if (rst) begin
         ms = SRST; ml = 0; mcalc = 0; mn = 0; me = EC_NONE;
      end else if (ms != SERR && (bus.err || bus.abort)) begin
         ms = SERR;
         me = bus.err ? EC_EXT : EC_ABORT;
      end else begin
         case (ms)
            SRST:    if (bus.start) ms = SREAD;
            SREAD:   begin ms = SLOAD; ml = 0; end
            SLOAD: begin
               if (ml < NL - 1) ml++;
               else begin ms = SCALC; ml = 0; mcalc = 0; end
            end
            SCALC: begin
               if (bus.finish) ms = SFINISH;
               else if (bus.nxt_line) ms = SWRITE;
               else begin
                  mcalc++;
                  if (MAXC > 0 && mcalc >= MAXC) begin
                     ms = SERR; me = EC_TIMEOUT;
                  end
               end
            end
            SWRITE: begin
               mn = (mn + 1 > CMAX) ? CMAX : mn + 1;
               ms = bus.step_mode ? SPAUSE : SREAD;
            end
            SPAUSE:
               if (bus.step || !bus.step_mode) ms = SREAD;
            SFINISH:
               if (bus.start) begin ms = SREAD; mn = 0; end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      logic bz;
      @(posedge clk);
      #1;
      model();
      bz = (ms inside {SREAD, SLOAD, SCALC, SWRITE, SPAUSE});
      chk("q", 32'(bus.q), 32'(ms));
      chk("count", 32'(bus.instr_count), 32'(mn));
      chk("cause", 32'(bus.err_cause), 32'(me));
      chk("busy", 32'(bus.busy), 32'(bz));
      if (ms == SLOAD || ms == SRST)
         chk("load_idx", 32'(bus.load_idx), 32'(ml));
   endtask

   task automatic idle_in();
      bus.start = 0; bus.nxt_line = 0; bus.finish = 0;
      bus.err = 0; bus.abort = 0; bus.step = 0;
      bus.step_mode = 0;
   endtask

   initial begin
      idle_in();
      // reset
      rst = 1; tick(); rst = 0;
      chk("rst_q", 32'(bus.q), 32'(SRST));
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_cnt", 32'(bus.instr_count), 0);
      chk("rst_lidx", 32'(bus.load_idx), 0);
      // one instruction, 3 loads, 2 calc cycles
      bus.start = 1; tick(); bus.start = 0;
      chk("s1_read", 32'(bus.q), 32'(SREAD));
      for (int i = 0; i < NL; i++) begin
         tick();
         chk("s1_load", 32'(bus.q), 32'(SLOAD));
         chk("s1_lidx", 32'(bus.load_idx), 32'(i));
      end
      tick(); chk("s1_calc1", 32'(bus.q), 32'(SCALC));
      tick(); chk("s1_calc2", 32'(bus.q), 32'(SCALC));
      bus.nxt_line = 1; tick(); bus.nxt_line = 0;
      chk("s1_write", 32'(bus.q), 32'(SWRITE));
      tick(); chk("s1_cnt", 32'(bus.instr_count), 1);
      // watchdog
      repeat (NL + 1) tick();
      repeat (MAXC - 1) tick();
      chk("wd_calc", 32'(bus.q), 32'(SCALC));
      tick();
      chk("wd_err", 32'(bus.q), 32'(SERR));
      chk("wd_cause", 32'(bus.err_cause), 32'(EC_TIMEOUT));
      chk("wd_busy", 32'(bus.busy), 0);
      rst = 1; tick(); rst = 0;
      // finish beats nxt_line, restart clears count
      bus.start = 1; tick(); bus.start = 0;
      repeat (NL + 1) tick();
      bus.nxt_line = 1; tick(); bus.nxt_line = 0;
      tick();
      repeat (NL + 1) tick();
      bus.finish = 1; bus.nxt_line = 1; tick();
      bus.finish = 0; bus.nxt_line = 0;
      chk("fin_q", 32'(bus.q), 32'(SFINISH));
      tick(); chk("fin_cnt", 32'(bus.instr_count), 1);
      bus.start = 1; tick(); bus.start = 0;
      chk("fin_restart", 32'(bus.q), 32'(SREAD));
      chk("fin_clr", 32'(bus.instr_count), 0);
      // step mode, two instructions
      bus.step_mode = 1;
      for (int n = 0; n < 2; n++) begin
         repeat (NL + 1) tick();
         bus.nxt_line = 1; tick(); bus.nxt_line = 0;
         tick(); chk("stp_pause", 32'(bus.q), 32'(SPAUSE));
         repeat (3) tick();
         chk("stp_hold", 32'(bus.q), 32'(SPAUSE));
         if (n == 0) begin
            bus.step = 1; tick(); bus.step = 0;
         end else begin
            bus.step_mode = 0; tick();
         end
         chk("stp_rel", 32'(bus.q), 32'(SREAD));
      end
      chk("stp_cnt", 32'(bus.instr_count), 2);
      // err + abort together in SLOAD
      tick();
      bus.err = 1; bus.abort = 1; tick();
      bus.err = 0; bus.abort = 0;
      chk("ea_q", 32'(bus.q), 32'(SERR));
      chk("ea_cause", 32'(bus.err_cause), 32'(EC_EXT));
      bus.start = 1; tick(); bus.start = 0;
      chk("ea_sticky", 32'(bus.q), 32'(SERR));
      rst = 1; tick(); rst = 0;
      chk("ea_rst", 32'(bus.err_cause), 32'(EC_NONE));
      // saturation, then reset mid-calc
      bus.start = 1; tick(); bus.start = 0;
      for (int n = 0; n < 5; n++) begin
         repeat (NL + 1) tick();
         bus.nxt_line = 1; tick(); bus.nxt_line = 0;
         tick();
      end
      chk("sat_cnt", 32'(bus.instr_count), CMAX);
      repeat (NL + 1) tick();
      chk("mid_calc", 32'(bus.q), 32'(SCALC));
      rst = 1; tick(); rst = 0;
      chk("mid_rst", 32'(bus.q), 32'(SRST));
      // random traffic
      for (int c = 0; c < 600; c++) begin
         rst          = ($urandom_range(63) == 0);
         bus.err      = ($urandom_range(79) == 0);
         bus.abort    = ($urandom_range(79) == 0);
         bus.start    = ($urandom_range(3) == 0);
         bus.nxt_line = ($urandom_range(3) == 0);
         bus.finish   = ($urandom_range(15) == 0);
         bus.step     = ($urandom_range(3) == 0);
         if ($urandom_range(7) == 0)
            bus.step_mode = ~bus.step_mode;
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
